// File: rtl/complex_div_arbiter_pkg.sv
// Shared types for the complex divider sharing logic: complex operand and
// result layouts, the FP status flags and a handy FP constant.
package complex_div_arbiter_pkg;

  localparam int DATA_W = 64;

  localparam logic [DATA_W-1:0] FP_ONE = 64'h3ff0000000000000;

  // One complex number, imaginary part in the upper half.
  typedef struct packed {
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } complex_t;

  // Divide operands: (a1 + j b1) / (a2 + j b2).
  typedef struct packed {
    logic [DATA_W-1:0] b2;
    logic [DATA_W-1:0] a2;
    logic [DATA_W-1:0] b1;
    logic [DATA_W-1:0] a1;
  } complex_op_t;

  // IEEE exception flags as reported by the floating-point units.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

endpackage

// File: rtl/complex_div_arbiter_if.sv
// Bus bundles around the shared divider: the requester-facing side and the
// divider-facing side. The master modport belongs to whoever initiates ops.
interface complex_div_arbiter_if
  import complex_div_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  logic        [NUM_REQ-1:0] req_valid;
  logic        [NUM_REQ-1:0] req_ready;
  complex_op_t [NUM_REQ-1:0] req_operands;
  logic        [NUM_REQ-1:0] rsp_valid;
  logic        [NUM_REQ-1:0] rsp_ready;
  complex_t                  rsp_result;
  status_t                   rsp_status;

  modport master (
    output req_valid, req_operands, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_status
  );

  modport slave (
    input  req_valid, req_operands, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_status
  );
endinterface

interface complex_div_if
  import complex_div_arbiter_pkg::*;
;
  complex_op_t operands;
  logic        in_valid;
  logic        in_ready;
  complex_t    result;
  status_t     status;
  logic        out_valid;
  logic        out_ready;
  logic        flush;

  modport master (
    output operands, in_valid, out_ready, flush,
    input  in_ready, result, status, out_valid
  );

  modport slave (
    input  operands, in_valid, out_ready, flush,
    output in_ready, result, status, out_valid
  );
endinterface

// File: rtl/complex_div_arbiter_rr_lock_arbiter.sv
// Round-robin arbiter whose grant is frozen once presented but not accepted,
// so a stalled requester keeps its slot until the handshake completes.
module rr_lock_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               enable,
  input  logic               ready,
  input  logic               flush,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               lock
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic [IDX_W-1:0] search_idx;
  logic             found;
  int               j;

  // Search for the first valid requester starting at the RR pointer.
  always_comb begin
    found      = 1'b0;
    search_idx = rr_ptr;
    j          = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && valid[j]) begin
        found      = 1'b1;
        search_idx = IDX_W'(j);
      end
    end
  end

  // A locked grant overrides the search result until it is accepted.
  always_comb begin
    grant_idx   = lock ? lock_idx : search_idx;
    grant_valid = enable & valid[grant_idx];
    grant_oh    = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  // Advance the pointer past each accepted grant; lock stalled grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (flush) begin
      lock <= 1'b0;
    end else if (grant_valid && ready) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      lock   <= 1'b0;
    end else if (grant_valid) begin
      lock     <= 1'b1;
      lock_idx <= grant_idx;
    end
  end

endmodule

// File: rtl/complex_div_arbiter.sv
// Shares one in-order complex divider between NUM_REQ requesters. Issue is
// round-robin with grant locking; a tag FIFO remembers who issued each op so
// the in-order results can be steered back to the right requester.
module complex_div_arbiter
  import complex_div_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  complex_div_arbiter_if.slave  req,
  complex_div_if.master         div,
  output logic                  busy,
  output logic                  err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [IDX_W-1:0] tag_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic [IDX_W-1:0] head;

  logic [NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               lock;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_INFLIGHT - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(MAX_INFLIGHT));
  assign head  = tag_mem[rd_ptr];

  rr_lock_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .valid       (req.req_valid),
    .enable      (~full & ~flush),
    .ready       (div.in_ready),
    .flush       (flush),
    .grant_oh    (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .lock        (lock)
  );

  // Issue side: the granted requester talks straight to the divider.
  always_comb begin
    div.in_valid  = grant_valid;
    div.operands  = req.req_operands[grant_idx];
    req.req_ready = div.in_ready ? grant_oh : '0;
    div.flush     = flush;
  end

  // Return side: steer the head result; drain stray results when empty.
  always_comb begin
    req.rsp_valid = '0;
    if (div.out_valid && !empty && !flush) req.rsp_valid[head] = 1'b1;
    div.out_ready  = ~flush & (empty ? div.out_valid : req.rsp_ready[head]);
    req.rsp_result = div.result;
    req.rsp_status = div.status;
  end

  assign push = grant_valid & div.in_ready;
  assign pop  = div.out_valid & div.out_ready & ~empty;
  assign busy = (count != '0) | lock;

  // Tag FIFO storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_idx;
  end

  // Tag FIFO pointers and occupancy; flush empties it in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Sticky flag for a divider result that nobody was waiting for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       err <= 1'b0;
    else if (div.out_valid && empty) err <= 1'b1;
  end

endmodule

// File: tb/tb_complex_div_arbiter.sv
// Directed bench for complex_div_arbiter; the bench plays both the
// requesters and the divider.
module tb_complex_div_arbiter;
  import complex_div_arbiter_pkg::*;

  localparam logic [63:0] TWO  = 64'h4000000000000000;
  localparam logic [63:0] HALF = 64'h3fe0000000000000;

  logic clk;
  logic rst;
  logic flush;
  logic busy;
  logic err;
  int   tests_run;
  int   tests_failed;

  complex_div_arbiter_if #(.NUM_REQ(2)) req_bus ();
  complex_div_if                        div_bus ();

  complex_div_arbiter #(
    .NUM_REQ      (2),
    .MAX_INFLIGHT (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .req   (req_bus.slave),
    .div   (div_bus.master),
    .busy  (busy),
    .err   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst                  = 1'b1;
    flush                = 1'b0;
    req_bus.req_valid    = '0;
    req_bus.req_operands = '0;
    req_bus.rsp_ready    = '0;
    div_bus.in_ready     = 1'b0;
    div_bus.result       = '0;
    div_bus.status       = '0;
    div_bus.out_valid    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++;
    if (div_bus.in_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_in_valid: got %b expected 0", div_bus.in_valid); end
    tests_run++;
    if (req_bus.req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 00", req_bus.req_ready); end
    tests_run++;
    if (req_bus.rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b expected 00", req_bus.rsp_valid); end
    tests_run++;
    if (div_bus.out_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_out_ready: got %b expected 0", div_bus.out_ready); end
    tests_run++;
    if ({busy, err} !== 2'b00) begin tests_failed++; $display("FAIL reset_busy_err: got %b expected 00", {busy, err}); end
  endtask

  task automatic test_single();
    complex_op_t op;
    complex_t    res;
    op  = '{b2: 64'h0, a2: TWO, b1: 64'h0, a1: FP_ONE};
    res = '{b: 64'h0, a: HALF};
    do_reset();
    req_bus.req_valid       = 2'b01;
    req_bus.req_operands[0] = op;
    div_bus.in_ready        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (req_bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL single_req_ready[%0d]: got %b expected 01", i, req_bus.req_ready); end
      tests_run++;
      if (div_bus.operands !== op) begin tests_failed++; $display("FAIL single_operands[%0d]: got %h expected %h", i, div_bus.operands, op); end
      @(negedge clk);
    end
    req_bus.req_valid = 2'b00;
    #1;
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b expected 1", busy); end
    div_bus.out_valid = 1'b1;
    div_bus.result    = res;
    req_bus.rsp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (req_bus.rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL single_rsp_valid[%0d]: got %b expected 01", i, req_bus.rsp_valid); end
      tests_run++;
      if (req_bus.rsp_result !== res) begin tests_failed++; $display("FAIL single_result[%0d]: got %h expected %h", i, req_bus.rsp_result, res); end
      tests_run++;
      if (div_bus.out_ready !== 1'b1) begin tests_failed++; $display("FAIL single_out_ready[%0d]: got %b expected 1", i, div_bus.out_ready); end
      @(negedge clk);
    end
    div_bus.out_valid = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle: got %b expected 0", busy); end
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_oh [4];
    logic [63:0] exp_a1 [4];
    exp_oh = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_a1 = '{64'h10, 64'h11, 64'h10, 64'h11};
    do_reset();
    req_bus.req_valid          = 2'b11;
    req_bus.req_operands[0].a1 = 64'h10;
    req_bus.req_operands[1].a1 = 64'h11;
    div_bus.in_ready           = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (req_bus.req_ready !== exp_oh[i]) begin tests_failed++; $display("FAIL alt_grant[%0d]: got %b expected %b", i, req_bus.req_ready, exp_oh[i]); end
      tests_run++;
      if (div_bus.operands.a1 !== exp_a1[i]) begin tests_failed++; $display("FAIL alt_operand[%0d]: got %h expected %h", i, div_bus.operands.a1, exp_a1[i]); end
      @(negedge clk);
    end
    req_bus.req_valid = 2'b00;
    div_bus.out_valid = 1'b1;
    req_bus.rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (req_bus.rsp_valid !== exp_oh[i]) begin tests_failed++; $display("FAIL alt_route[%0d]: got %b expected %b", i, req_bus.rsp_valid, exp_oh[i]); end
      @(negedge clk);
    end
    div_bus.out_valid = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    req_bus.req_valid          = 2'b10;
    req_bus.req_operands[0].a1 = 64'hA0;
    req_bus.req_operands[1].a1 = 64'hA1;
    div_bus.in_ready           = 1'b0;
    #1;
    tests_run++;
    if ({div_bus.in_valid, req_bus.req_ready} !== 3'b100) begin tests_failed++; $display("FAIL lock_first: got %b expected 100", {div_bus.in_valid, req_bus.req_ready}); end
    @(negedge clk);
    req_bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (div_bus.operands.a1 !== 64'hA1) begin tests_failed++; $display("FAIL lock_hold[%0d]: got %h expected a1", i, div_bus.operands.a1); end
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("FAIL lock_busy[%0d]: got %b expected 1", i, busy); end
      @(negedge clk);
    end
    div_bus.in_ready = 1'b1;
    #1;
    tests_run++;
    if (req_bus.req_ready !== 2'b10) begin tests_failed++; $display("FAIL lock_release: got %b expected 10", req_bus.req_ready); end
    @(negedge clk);
    #1;
    tests_run++;
    if (req_bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL lock_next: got %b expected 01", req_bus.req_ready); end
    @(negedge clk);
    req_bus.req_valid = 2'b00;
    div_bus.out_valid = 1'b1;
    req_bus.rsp_ready = 2'b11;
    #1;
    tests_run++;
    if (req_bus.rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL lock_rsp0: got %b expected 10", req_bus.rsp_valid); end
    @(negedge clk);
    #1;
    tests_run++;
    if (req_bus.rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL lock_rsp1: got %b expected 01", req_bus.rsp_valid); end
    @(negedge clk);
    div_bus.out_valid = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    req_bus.req_valid = 2'b01;
    div_bus.in_ready  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests_run++;
      if (req_bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL full_fill[%0d]: got %b expected 01", i, req_bus.req_ready); end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if ({div_bus.in_valid, req_bus.req_ready} !== 3'b000) begin tests_failed++; $display("FAIL full_block: got %b expected 000", {div_bus.in_valid, req_bus.req_ready}); end
    div_bus.out_valid = 1'b1;
    req_bus.rsp_ready = 2'b01;
    #1;
    tests_run++;
    if (req_bus.rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL full_pop_valid: got %b expected 01", req_bus.rsp_valid); end
    tests_run++;
    if (div_bus.in_valid !== 1'b0) begin tests_failed++; $display("FAIL full_no_bypass: got %b expected 0", div_bus.in_valid); end
    @(negedge clk);
    div_bus.out_valid = 1'b0;
    req_bus.rsp_ready = 2'b00;
    #1;
    tests_run++;
    if (req_bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL full_reissue: got %b expected 01", req_bus.req_ready); end
    @(negedge clk);
    #1;
    tests_run++;
    if (div_bus.in_valid !== 1'b0) begin tests_failed++; $display("FAIL full_again: got %b expected 0", div_bus.in_valid); end
    req_bus.req_valid = 2'b00;
  endtask

  task automatic test_flush();
    do_reset();
    req_bus.req_valid = 2'b11;
    div_bus.in_ready  = 1'b1;
    repeat (5) @(negedge clk);
    flush             = 1'b1;
    div_bus.out_valid = 1'b1;
    req_bus.rsp_ready = 2'b11;
    #1;
    tests_run++;
    if (div_bus.flush !== 1'b1) begin tests_failed++; $display("FAIL flush_fwd: got %b expected 1", div_bus.flush); end
    tests_run++;
    if ({div_bus.in_valid, req_bus.req_ready} !== 3'b000) begin tests_failed++; $display("FAIL flush_no_issue: got %b expected 000", {div_bus.in_valid, req_bus.req_ready}); end
    tests_run++;
    if (req_bus.rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL flush_no_rsp: got %b expected 00", req_bus.rsp_valid); end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
    @(negedge clk);
    flush             = 1'b0;
    div_bus.out_valid = 1'b0;
    req_bus.req_valid = 2'b00;
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy_after: got %b expected 0", busy); end
    tests_run++;
    if (req_bus.rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL flush_rsp_after: got %b expected 00", req_bus.rsp_valid); end
    req_bus.req_valid = 2'b11;
    #1;
    tests_run++;
    if (req_bus.req_ready !== 2'b10) begin tests_failed++; $display("FAIL flush_rr_kept: got %b expected 10", req_bus.req_ready); end
    @(negedge clk);
    req_bus.req_valid = 2'b00;
  endtask

  task automatic test_err();
    do_reset();
    div_bus.out_valid = 1'b1;
    #1;
    tests_run++;
    if (div_bus.out_ready !== 1'b1) begin tests_failed++; $display("FAIL err_drain: got %b expected 1", div_bus.out_ready); end
    tests_run++;
    if ({req_bus.rsp_valid, err} !== 3'b000) begin tests_failed++; $display("FAIL err_pre: got %b expected 000", {req_bus.rsp_valid, err}); end
    @(negedge clk);
    div_bus.out_valid = 1'b0;
    #1;
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL err_set: got %b expected 1", err); end
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b expected 1", err); end
    rst = 1'b1;
    #1;
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL err_cleared: got %b expected 0", err); end
    do_reset();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_alternate();
    test_lock();
    test_full();
    test_flush();
    test_err();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
